// File: rtl/alu_vec_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_vec_pkg
//  Brief    : Opcode encoding and saturation helper for the vector ALU.
//  Revision : 1.0  initial release
// ============================================================================
package alu_vec_pkg;

    localparam int c_OP_LEN = 3;

    typedef enum logic [c_OP_LEN-1:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_MUL   = 3'd2,
        OP_MIN   = 3'd3,
        OP_MAX   = 3'd4,
        OP_SLL   = 3'd5,
        OP_SRA   = 3'd6,
        OP_PASSA = 3'd7
    } op_e;

    // Clamp value as {msb, fill}: the caller replicates fill below msb,
    // which keeps this helper independent of the lane width.
    function automatic logic [1:0] sat_clamp(input logic neg);
        return {neg, ~neg};
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_vec_lane.sv
`default_nettype none
// ============================================================================
//  Module   : alu_vec_lane
//  Brief    : One lane of combinational op, overflow, saturation and flag logic.
//  Revision : 1.0  initial release
// ============================================================================
module alu_vec_lane
    import alu_vec_pkg::*;
#(
    parameter int VDW_P = 32
) (
    input  logic [VDW_P-1:0] i_a,
    input  logic [VDW_P-1:0] i_b,
    input  op_e              i_op,
    input  logic             i_sat,
    input  logic             i_mask,
    output logic [VDW_P-1:0] o_res,
    output logic             o_ov,
    output logic             o_zero,
    output logic             o_neg
);

    localparam int c_SH_W = $clog2(VDW_P);

    logic [VDW_P:0]     w_sum;
    logic [VDW_P:0]     w_diff;
    logic [2*VDW_P-1:0] w_prod;
    logic [c_SH_W-1:0]  w_shamt;
    logic               w_lt;
    logic [VDW_P-1:0]   w_raw;
    logic               w_ov;
    logic               w_neg_true;
    logic [1:0]         w_clamp_pat;
    logic [VDW_P-1:0]   w_clamp;
    logic [VDW_P-1:0]   w_final;

    // One guard bit for add/sub and a double-width product give the exact
    // result, so overflow is simply "upper bits are not a sign extension".
    assign w_sum   = {i_a[VDW_P-1], i_a} + {i_b[VDW_P-1], i_b};
    assign w_diff  = {i_a[VDW_P-1], i_a} - {i_b[VDW_P-1], i_b};
    assign w_prod  = {{VDW_P{i_a[VDW_P-1]}}, i_a} * {{VDW_P{i_b[VDW_P-1]}}, i_b};
    assign w_shamt = i_b[c_SH_W-1:0];
    assign w_lt    = $signed(i_a) < $signed(i_b);

    always_comb begin
        w_raw      = i_a;
        w_ov       = 1'b0;
        w_neg_true = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_raw      = w_sum[VDW_P-1:0];
                w_ov       = w_sum[VDW_P] ^ w_sum[VDW_P-1];
                w_neg_true = w_sum[VDW_P];
            end
            OP_SUB: begin
                w_raw      = w_diff[VDW_P-1:0];
                w_ov       = w_diff[VDW_P] ^ w_diff[VDW_P-1];
                w_neg_true = w_diff[VDW_P];
            end
            OP_MUL: begin
                w_raw      = w_prod[VDW_P-1:0];
                w_ov       = w_prod[2*VDW_P-1:VDW_P-1] != {(VDW_P+1){w_prod[2*VDW_P-1]}};
                w_neg_true = w_prod[2*VDW_P-1];
            end
            OP_MIN:   w_raw = w_lt ? i_a : i_b;
            OP_MAX:   w_raw = w_lt ? i_b : i_a;
            OP_SLL:   w_raw = i_a << w_shamt;
            OP_SRA:   w_raw = $signed(i_a) >>> w_shamt;
            OP_PASSA: w_raw = i_a;
            default:  w_raw = i_a;
        endcase
    end

    assign w_clamp_pat = sat_clamp(w_neg_true);
    assign w_clamp     = {w_clamp_pat[1], {(VDW_P-1){w_clamp_pat[0]}}};
    assign w_final     = (i_sat && w_ov) ? w_clamp : w_raw;

    always_comb begin
        o_res  = i_a;
        o_ov   = 1'b0;
        o_zero = 1'b0;
        o_neg  = 1'b0;
        if (i_mask) begin
            o_res  = w_final;
            o_ov   = w_ov;
            o_zero = (w_final == '0);
            o_neg  = w_final[VDW_P-1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_vec_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : alu_vec_pipe
//  Brief    : Multi-lane pipelined ALU with valid/ready stall-all handshake.
//  Revision : 1.0  initial release
// ============================================================================
module alu_vec_pipe
    import alu_vec_pkg::*;
#(
    parameter int VDW_P    = 32,
    parameter int LANES_P  = 4,
    parameter int OP_LEN_P = 3,
    parameter int STAGES_P = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     v_i,
    output logic                     ready_o,
    input  logic [LANES_P*VDW_P-1:0] a_i,
    input  logic [LANES_P*VDW_P-1:0] b_i,
    input  logic [OP_LEN_P-1:0]      op_i,
    input  logic                     sat_i,
    input  logic [LANES_P-1:0]       mask_i,
    output logic                     v_o,
    input  logic                     ready_i,
    output logic [LANES_P*VDW_P-1:0] result_o,
    output logic [LANES_P-1:0]       flag_overflow_o,
    output logic [LANES_P-1:0]       flag_zero_o,
    output logic [LANES_P-1:0]       flag_negative_o
);

    op_e                      w_op;
    logic                     w_advance;
    logic [LANES_P*VDW_P-1:0] w_res;
    logic [LANES_P-1:0]       w_ov;
    logic [LANES_P-1:0]       w_zero;
    logic [LANES_P-1:0]       w_neg;

    logic                     r_v    [STAGES_P];
    logic [LANES_P*VDW_P-1:0] r_res  [STAGES_P];
    logic [LANES_P-1:0]       r_ov   [STAGES_P];
    logic [LANES_P-1:0]       r_zero [STAGES_P];
    logic [LANES_P-1:0]       r_neg  [STAGES_P];

    assign w_op = op_e'(op_i);

    generate
        for (genvar k = 0; k < LANES_P; k++) begin : g_lane
            alu_vec_lane #(
                .VDW_P (VDW_P)
            ) u_lane (
                .i_a    (a_i[k*VDW_P +: VDW_P]),
                .i_b    (b_i[k*VDW_P +: VDW_P]),
                .i_op   (w_op),
                .i_sat  (sat_i),
                .i_mask (mask_i[k]),
                .o_res  (w_res[k*VDW_P +: VDW_P]),
                .o_ov   (w_ov[k]),
                .o_zero (w_zero[k]),
                .o_neg  (w_neg[k])
            );
        end
    endgenerate

    // Whole pipe moves together; only a held output can stop it.
    assign w_advance = ~r_v[STAGES_P-1] | ready_i;
    assign ready_o   = w_advance;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int s = 0; s < STAGES_P; s++) begin
                r_v[s]    <= 1'b0;
                r_res[s]  <= '0;
                r_ov[s]   <= '0;
                r_zero[s] <= '0;
                r_neg[s]  <= '0;
            end
        end else if (w_advance) begin
            r_v[0]    <= v_i;
            r_res[0]  <= w_res;
            r_ov[0]   <= w_ov;
            r_zero[0] <= w_zero;
            r_neg[0]  <= w_neg;
            for (int s = 1; s < STAGES_P; s++) begin
                r_v[s]    <= r_v[s-1];
                r_res[s]  <= r_res[s-1];
                r_ov[s]   <= r_ov[s-1];
                r_zero[s] <= r_zero[s-1];
                r_neg[s]  <= r_neg[s-1];
            end
        end
    end

    assign v_o             = r_v[STAGES_P-1];
    assign result_o        = r_res[STAGES_P-1];
    assign flag_overflow_o = r_ov[STAGES_P-1];
    assign flag_zero_o     = r_zero[STAGES_P-1];
    assign flag_negative_o = r_neg[STAGES_P-1];

endmodule
`default_nettype wire

// File: tb/tb_alu_vec_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_vec_pipe
//  Brief    : Randomized and directed self-checking bench for alu_vec_pipe.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_vec_pipe;

    localparam int c_ST = 2;

    logic         clk = 1'b0;
    logic         reset_i = 1'b1;
    logic         v_i = 1'b0;
    logic         ready_i = 1'b1;
    logic         sat_i = 1'b0;
    logic [127:0] a_i = '0;
    logic [127:0] b_i = '0;
    logic [2:0]   op_i = '0;
    logic [3:0]   mask_i = '1;
    logic         ready_o;
    logic         v_o;
    logic [127:0] result_o;
    logic [3:0]   flag_overflow_o;
    logic [3:0]   flag_zero_o;
    logic [3:0]   flag_negative_o;

    always #5 clk = ~clk;

    alu_vec_pipe dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .v_i             (v_i),
        .ready_o         (ready_o),
        .a_i             (a_i),
        .b_i             (b_i),
        .op_i            (op_i),
        .sat_i           (sat_i),
        .mask_i          (mask_i),
        .v_o             (v_o),
        .ready_i         (ready_i),
        .result_o        (result_o),
        .flag_overflow_o (flag_overflow_o),
        .flag_zero_o     (flag_zero_o),
        .flag_negative_o (flag_negative_o)
    );

    typedef struct {
        logic [127:0] res;
        logic [3:0]   ov;
        logic [3:0]   z;
        logic [3:0]   n;
        int           acc;
    } exp_t;

    exp_t         exp_q[$];
    int           n_pass = 0;
    int           n_chk = 0;
    int           cyc = 0;
    int           n_retired = 0;
    bit           lat_en = 0;
    bit           rst_req = 0;
    bit           acc_flag = 0;
    bit           stall_prev = 0;
    logic [127:0] s_res;
    logic [11:0]  s_flags;
    logic [127:0] last_res;
    logic [3:0]   last_ov, last_z, last_n;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [127:0] pk(input int l0, input int l1, input int l2, input int l3);
        return {l3[31:0], l2[31:0], l1[31:0], l0[31:0]};
    endfunction

    // Reference: exact arithmetic in 64-bit integers, then apply the lane rules.
    function automatic exp_t model(input logic [127:0] a, input logic [127:0] b,
                                   input logic [2:0] op, input logic sat, input logic [3:0] m);
        exp_t        e;
        longint      sa, sb, full;
        logic [31:0] ua, ub, r;
        logic        ov;
        e.res = '0; e.ov = '0; e.z = '0; e.n = '0; e.acc = 0;
        for (int k = 0; k < 4; k++) begin
            ua   = a[k*32 +: 32];
            ub   = b[k*32 +: 32];
            sa   = longint'($signed(ua));
            sb   = longint'($signed(ub));
            full = 0;
            case (op)
                3'd0: full = sa + sb;
                3'd1: full = sa - sb;
                3'd2: full = sa * sb;
                3'd3: full = (sa < sb) ? sa : sb;
                3'd4: full = (sa > sb) ? sa : sb;
                3'd5: full = longint'(ua) << ub[4:0];
                3'd6: full = sa >>> ub[4:0];
                default: full = sa;
            endcase
            ov = (op <= 3'd2) && ((full > 64'sh7FFFFFFF) || (full < -64'sh80000000));
            r  = full[31:0];
            if (sat && ov) r = (full < 0) ? 32'h80000000 : 32'h7FFFFFFF;
            if (!m[k]) begin
                r  = ua;
                ov = 1'b0;
            end
            e.res[k*32 +: 32] = r;
            e.ov[k] = ov;
            e.z[k]  = m[k] && (r == 32'd0);
            e.n[k]  = m[k] && r[31];
        end
        return e;
    endfunction

    task automatic step(input logic vi, input logic [127:0] a, input logic [127:0] b,
                        input logic [2:0] op, input logic sat, input logic [3:0] m,
                        input logic rdy);
        exp_t e;
        logic exp_rdy;
        @(negedge clk);
        reset_i = rst_req;
        v_i = vi; a_i = a; b_i = b; op_i = op; sat_i = sat; mask_i = m; ready_i = rdy;
        acc_flag = 0;
        #1;
        if (!reset_i) begin
            exp_rdy = !v_o || rdy;
            check("ready_o", ready_o, exp_rdy);
            if (stall_prev) begin
                check("stall_v", v_o, 1'b1);
                check("stall_res", result_o, s_res);
                check("stall_flags", {flag_overflow_o, flag_zero_o, flag_negative_o}, s_flags);
            end
            if (v_o && rdy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", v_o, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("res", result_o, e.res);
                    check("ovf", flag_overflow_o, e.ov);
                    check("zero", flag_zero_o, e.z);
                    check("neg", flag_negative_o, e.n);
                    if (lat_en) check("latency", cyc - e.acc, c_ST);
                end
                last_res = result_o;
                last_ov  = flag_overflow_o;
                last_z   = flag_zero_o;
                last_n   = flag_negative_o;
                n_retired++;
            end
            if (vi && ready_o) begin
                e = model(a, b, op, sat, m);
                e.acc = cyc;
                exp_q.push_back(e);
                acc_flag = 1;
            end
            stall_prev = v_o && !rdy;
            s_res      = result_o;
            s_flags    = {flag_overflow_o, flag_zero_o, flag_negative_o};
        end else begin
            stall_prev = 0;
        end
        cyc++;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, '0, '0, 3'd0, 1'b0, 4'hF, rdy);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1'b1);
        check("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
        idle(1'b1);
        idle(1'b1);
    endtask

    task automatic do_reset();
        rst_req = 1;
        idle(1'b1);
        rst_req = 0;
        exp_q.delete();
        stall_prev = 0;
        @(posedge clk);
        #1;
        check("rst_v", v_o, 1'b0);
        check("rst_res", result_o, '0);
        check("rst_flags", {flag_overflow_o, flag_zero_o, flag_negative_o}, '0);
    endtask

    function automatic logic [31:0] rw();
        case ($urandom_range(0, 5))
            0: return 32'h7FFFFFFF;
            1: return 32'h80000000;
            2: return 32'($urandom_range(0, 40));
            3: return -32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [127:0] rv();
        return {rw(), rw(), rw(), rw()};
    endfunction

    logic [127:0] st_a [8];
    logic [127:0] st_b [8];
    logic [2:0]   st_op [8];
    logic         st_sat [8];
    int           base, idx;

    initial begin
        do_reset();

        // Latency and basic add.
        lat_en = 1;
        step(1'b1, pk(1, 1, 1, 1), pk(1, 1, 1, 1), 3'd0, 1'b0, 4'hF, 1'b1);
        drain();
        check("t1_res", last_res, pk(2, 2, 2, 2));
        check("t1_flags", {last_ov, last_z, last_n}, '0);

        step(1'b1, pk(10, 4, -3, 7), pk(8, 10, 3, 7), 3'd1, 1'b0, 4'hF, 1'b1);
        drain();
        check("sub_res", last_res, pk(2, -6, -6, 0));
        check("sub_n", last_n, 4'b0110);
        check("sub_z", last_z, 4'b1000);

        step(1'b1, {4{32'h7FFFFFFF}}, pk(1, 1, 1, 1), 3'd0, 1'b0, 4'hF, 1'b1);
        drain();
        check("wrap_res", last_res, {4{32'h80000000}});
        check("wrap_vn", {last_ov, last_n}, 8'hFF);
        step(1'b1, {4{32'h7FFFFFFF}}, pk(1, 1, 1, 1), 3'd0, 1'b1, 4'hF, 1'b1);
        drain();
        check("sat_res", last_res, {4{32'h7FFFFFFF}});
        check("sat_vn", {last_ov, last_n}, 8'hF0);

        step(1'b1, pk(11, 11, 11, 11), pk(4, 4, 4, 4), 3'd2, 1'b0, 4'hF, 1'b1);
        drain();
        check("mul_res", last_res, pk(44, 44, 44, 44));
        step(1'b1, pk(-5, -5, -5, -5), pk(3, 3, 3, 3), 3'd3, 1'b0, 4'hF, 1'b1);
        drain();
        check("min_res", last_res, pk(-5, -5, -5, -5));
        step(1'b1, pk(-5, -5, -5, -5), pk(3, 3, 3, 3), 3'd4, 1'b0, 4'hF, 1'b1);
        drain();
        check("max_res", last_res, pk(3, 3, 3, 3));
        step(1'b1, pk(-16, -16, -16, -16), pk(2, 2, 2, 2), 3'd6, 1'b0, 4'hF, 1'b1);
        drain();
        check("sra_res", last_res, pk(-4, -4, -4, -4));
        step(1'b1, pk(1, 1, 1, 1), pk(31, 31, 31, 31), 3'd5, 1'b1, 4'hF, 1'b1);
        drain();
        check("sll_res", last_res, {4{32'h80000000}});
        check("sll_v", last_ov, 4'h0);

        step(1'b1, pk(5, 5, 5, 5), pk(5, 5, 5, 5), 3'd0, 1'b0, 4'b0101, 1'b1);
        drain();
        check("mask_res", last_res, pk(10, 5, 10, 5));
        check("mask_flags", {last_ov, last_z, last_n}, '0);
        lat_en = 0;

        // Eight back-to-back ops with a three-cycle downstream stall.
        for (int i = 0; i < 8; i++) begin
            st_a[i] = rv(); st_b[i] = rv();
            st_op[i] = 3'($urandom_range(0, 7)); st_sat[i] = 1'($urandom_range(0, 1));
        end
        base = n_retired;
        idx = 0;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            step(1'b1, st_a[idx], st_b[idx], st_op[idx], st_sat[idx], 4'hF,
                 (c >= 3 && c < 6) ? 1'b0 : 1'b1);
            if (acc_flag) idx++;
        end
        drain();
        check("stream_count", n_retired - base, 8);

        // Random traffic with random backpressure and bubbles.
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 3) != 0), rv(), rv(), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 3) != 0));
        drain();

        // Unstalled random stream: every op must arrive exactly c_ST cycles later.
        lat_en = 1;
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 1)), rv(), rv(), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 4'($urandom), 1'b1);
        drain();
        lat_en = 0;

        // Reset mid-stream: in-flight ops must never appear.
        for (int i = 0; i < 4; i++)
            step(1'b1, rv(), rv(), 3'($urandom_range(0, 7)), 1'b0, 4'hF, 1'b1);
        base = n_retired;
        do_reset();
        for (int i = 0; i < 6; i++) idle(1'b1);
        check("no_stale", n_retired - base, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
